// File: rtl/wave_meas_if.sv
// Sample stream, control and result bundle for wave_meas.
// The master side feeds samples/requests; the slave side is the measurement block.
interface wave_meas_if #(
  parameter int unsigned DT_W  = 8,
  parameter int unsigned CNT_W = 24
);
  logic             din_valid;
  logic [DT_W-1:0]  din;
  logic             start;
  logic [7:0]       n_periods;
  logic             busy;
  logic             done;
  logic [DT_W-1:0]  vmax;
  logic [DT_W-1:0]  vmin;
  logic [DT_W-1:0]  vpp;
  logic [CNT_W-1:0] period_sum;
  logic             err_flat;
  logic             err_timeout;

  modport master (
    output din_valid, din, start, n_periods,
    input  busy, done, vmax, vmin, vpp, period_sum, err_flat, err_timeout
  );

  modport slave (
    input  din_valid, din, start, n_periods,
    output busy, done, vmax, vmin, vpp, period_sum, err_flat, err_timeout
  );
endinterface

// File: rtl/wave_meas.sv
// Waveform loop-back checker: scans min/max, derives a hysteretic mid threshold,
// then measures the length in samples of N periods between rising crossings.
module wave_meas #(
  parameter int unsigned DT_W     = 8,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned SCAN_LEN = 1024,
  parameter int unsigned HYST     = 8
) (
  input logic        clk,
  input logic        rst,
  wave_meas_if.slave bus
);

  localparam int unsigned    ScanW    = $clog2(SCAN_LEN + 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_LEN - 1);
  localparam logic [DT_W:0]  HystW    = (DT_W+1)'(HYST);
  localparam logic [DT_W:0]  FlatMin  = (DT_W+1)'(2 * HYST + 1);
  localparam logic [DT_W:0]  DtMax    = {1'b0, {DT_W{1'b1}}};

  typedef enum logic [2:0] {StIdle, StScan, StArm, StHunt, StCount, StDone} state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [DT_W-1:0]   vmax_q, vmax_d, vmin_q, vmin_d, vpp_q, vpp_d;
  logic [CNT_W-1:0]  psum_q, psum_d;
  logic              err_flat_q, err_flat_d, err_tmo_q, err_tmo_d;
  logic [DT_W-1:0]   max_q, max_d, min_q, min_d, hi_q, hi_d, lo_q, lo_d;
  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [7:0]        n_q, n_d, edge_q, edge_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d, smp_q, smp_d;
  logic              low_q, low_d;

  logic [DT_W-1:0]   scan_max, scan_min, scan_vpp, hi_sat, lo_sat;
  logic [DT_W:0]     thr, hi_ext, lo_ext;
  logic [CNT_W-1:0]  tmo_inc, smp_inc;
  logic [7:0]        edge_inc;
  logic              finish;

  // Extremes including the current sample, and thresholds derived from them.
  always_comb begin
    scan_max = (bus.din > max_q) ? bus.din : max_q;
    scan_min = (bus.din < min_q) ? bus.din : min_q;
    scan_vpp = scan_max - scan_min;
    thr      = ({1'b0, scan_max} + {1'b0, scan_min}) >> 1;
    hi_ext   = thr + HystW;
    lo_ext   = thr - HystW;
    hi_sat   = (hi_ext > DtMax) ? '1 : hi_ext[DT_W-1:0];
    lo_sat   = (thr < HystW) ? '0 : lo_ext[DT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    vmax_d     = vmax_q;
    vmin_d     = vmin_q;
    vpp_d      = vpp_q;
    psum_d     = psum_q;
    err_flat_d = err_flat_q;
    err_tmo_d  = err_tmo_q;
    max_d      = max_q;
    min_d      = min_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    scan_cnt_d = scan_cnt_q;
    n_d        = n_q;
    edge_d     = edge_q;
    tmo_d      = tmo_q;
    smp_d      = smp_q;
    low_d      = low_q;
    tmo_inc    = tmo_q + CNT_W'(1);
    smp_inc    = smp_q + CNT_W'(1);
    edge_inc   = edge_q + 8'd1;
    finish     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // done_q high means this is the completion cycle, where start is ignored.
        if (bus.start && !done_q) begin
          state_d    = StScan;
          busy_d     = 1'b1;
          vmax_d     = '0;
          vmin_d     = '0;
          vpp_d      = '0;
          psum_d     = '0;
          err_flat_d = 1'b0;
          err_tmo_d  = 1'b0;
          max_d      = '0;
          min_d      = '1;
          scan_cnt_d = '0;
          n_d        = (bus.n_periods == 8'd0) ? 8'd1 : bus.n_periods;
        end
      end
      StScan: begin
        if (bus.din_valid) begin
          max_d      = scan_max;
          min_d      = scan_min;
          scan_cnt_d = scan_cnt_q + ScanW'(1);
          if (scan_cnt_q == ScanLast) begin
            vmax_d = scan_max;
            vmin_d = scan_min;
            vpp_d  = scan_vpp;
            hi_d   = hi_sat;
            lo_d   = lo_sat;
            tmo_d  = '0;
            if ({1'b0, scan_vpp} < FlatMin) begin
              err_flat_d = 1'b1;
              psum_d     = '0;
              state_d    = StDone;
            end else begin
              state_d = StArm;
            end
          end
        end
      end
      StArm: begin
        if (bus.din_valid && bus.din <= lo_q) state_d = StHunt;
      end
      StHunt: begin
        if (bus.din_valid && bus.din >= hi_q) begin
          smp_d   = '0;
          edge_d  = '0;
          low_d   = 1'b0;
          state_d = StCount;
        end
      end
      StCount: begin
        if (bus.din_valid) begin
          smp_d = smp_inc;
          if (bus.din <= lo_q) low_d = 1'b1;
          // Crossing uses the flag as it stood before this sample.
          if (bus.din >= hi_q && low_q) begin
            edge_d = edge_inc;
            low_d  = 1'b0;
            if (edge_inc == n_q) begin
              psum_d  = smp_inc;
              state_d = StDone;
              finish  = 1'b1;
            end
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A sample that completes the measurement wins over a coincident saturation.
    if (bus.din_valid && (state_q inside {StArm, StHunt, StCount})) begin
      tmo_d = tmo_inc;
      if (!finish && (&tmo_inc)) begin
        err_tmo_d = 1'b1;
        psum_d    = '0;
        state_d   = StDone;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vmax_q     <= '0;
      vmin_q     <= '0;
      vpp_q      <= '0;
      psum_q     <= '0;
      err_flat_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      max_q      <= '0;
      min_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      scan_cnt_q <= '0;
      n_q        <= '0;
      edge_q     <= '0;
      tmo_q      <= '0;
      smp_q      <= '0;
      low_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vmax_q     <= vmax_d;
      vmin_q     <= vmin_d;
      vpp_q      <= vpp_d;
      psum_q     <= psum_d;
      err_flat_q <= err_flat_d;
      err_tmo_q  <= err_tmo_d;
      max_q      <= max_d;
      min_q      <= min_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      scan_cnt_q <= scan_cnt_d;
      n_q        <= n_d;
      edge_q     <= edge_d;
      tmo_q      <= tmo_d;
      smp_q      <= smp_d;
      low_q      <= low_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.vmax        = vmax_q;
  assign bus.vmin        = vmin_q;
  assign bus.vpp         = vpp_q;
  assign bus.period_sum  = psum_q;
  assign bus.err_flat    = err_flat_q;
  assign bus.err_timeout = err_tmo_q;

endmodule

// File: tb/tb_wave_meas.sv
// Directed bench for wave_meas: a 24-bit instance for the main scenarios and an
// 8-bit-counter instance for the timeout scenario.
module tb_wave_meas;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_v = 1'b0;
  logic [7:0] din_s = 8'd0;
  logic       start_s = 1'b0;
  logic [7:0] n_s = 8'd0;
  logic       sel = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         cyc;
  logic       got;

  always #5 clk = ~clk;

  wave_meas_if #(.DT_W(8), .CNT_W(24)) bus_a ();
  wave_meas_if #(.DT_W(8), .CNT_W(8))  bus_b ();

  assign bus_a.din_valid = din_v;
  assign bus_a.din       = din_s;
  assign bus_a.start     = start_s & ~sel;
  assign bus_a.n_periods = n_s;
  assign bus_b.din_valid = din_v;
  assign bus_b.din       = din_s;
  assign bus_b.start     = start_s & sel;
  assign bus_b.n_periods = n_s;

  wave_meas #(.DT_W(8), .CNT_W(24), .SCAN_LEN(64), .HYST(8)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  wave_meas #(.DT_W(8), .CNT_W(8), .SCAN_LEN(64), .HYST(8)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  logic        done_o, busy_o;
  logic [31:0] psum_o;
  always_comb begin
    done_o = sel ? bus_b.done : bus_a.done;
    busy_o = sel ? bus_b.busy : bus_a.busy;
    psum_o = sel ? 32'(bus_b.period_sum) : 32'(bus_a.period_sum);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: square 10x200/10x55; mode 1: constant 128; mode 2: square then held at 200
  function automatic logic [7:0] wave(input int idx, input int mode);
    if (mode == 1) return 8'd128;
    if (mode == 2 && idx >= 64) return 8'd200;
    return ((idx % 20) < 10) ? 8'd200 : 8'd55;
  endfunction

  task automatic run(input int mode, input int stride, input logic [7:0] n, input int extra,
                     input int stop_at, output int ncyc, output logic gotd);
    int idx;
    idx   = 0;
    ncyc  = 0;
    gotd  = 1'b0;
    n_s   = n;
    din_v = 1'b0;
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    check("busy_after_start", 32'(busy_o), 1);
    check("clear_on_start", psum_o, 0);
    while (ncyc < 3000 && !gotd && ncyc != stop_at) begin
      start_s = (ncyc == extra);
      if (ncyc == extra) n_s = 8'd4;
      din_v = ((ncyc % stride) == 0);
      din_s = wave(idx, mode);
      if (din_v) idx++;
      @(posedge clk);
      #1;
      ncyc++;
      gotd = done_o;
    end
    start_s = 1'b0;
    din_v   = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(bus_a.busy), 0);
    check("rst_done", 32'(bus_a.done), 0);
    check("rst_vmin", 32'(bus_a.vmin), 0);
    check("rst_psum", 32'(bus_a.period_sum), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(bus_a.busy), 0);

    // 1: continuous square wave, N=4
    run(0, 1, 8'd4, -1, -1, cyc, got);
    check("t1_done", 32'(got), 1);
    check("t1_cycles", 32'(cyc), 162);
    check("t1_busy_at_done", 32'(bus_a.busy), 0);
    check("t1_vmax", 32'(bus_a.vmax), 200);
    check("t1_vmin", 32'(bus_a.vmin), 55);
    check("t1_vpp", 32'(bus_a.vpp), 145);
    check("t1_psum", 32'(bus_a.period_sum), 80);
    check("t1_flat", 32'(bus_a.err_flat), 0);
    check("t1_tmo", 32'(bus_a.err_timeout), 0);
    @(posedge clk);
    #1;
    check("t1_done_one_cycle", 32'(bus_a.done), 0);
    check("t1_psum_held", 32'(bus_a.period_sum), 80);

    // 2: valid every third cycle
    run(0, 3, 8'd4, -1, -1, cyc, got);
    check("t2_done", 32'(got), 1);
    check("t2_cycles", 32'(cyc), 482);
    check("t2_vmax", 32'(bus_a.vmax), 200);
    check("t2_vmin", 32'(bus_a.vmin), 55);
    check("t2_psum", 32'(bus_a.period_sum), 80);
    @(posedge clk);
    #1;

    // 3: flat input
    run(1, 1, 8'd4, -1, -1, cyc, got);
    check("t3_done", 32'(got), 1);
    check("t3_cycles", 32'(cyc), 65);
    check("t3_flat", 32'(bus_a.err_flat), 1);
    check("t3_vpp", 32'(bus_a.vpp), 0);
    check("t3_vmax", 32'(bus_a.vmax), 128);
    check("t3_psum", 32'(bus_a.period_sum), 0);
    check("t3_tmo", 32'(bus_a.err_timeout), 0);
    @(posedge clk);
    #1;

    // 4: 8-bit counter instance, wave stops high after the scan
    sel = 1'b1;
    run(2, 1, 8'd4, -1, -1, cyc, got);
    check("t4_done", 32'(got), 1);
    check("t4_cycles", 32'(cyc), 320);
    check("t4_tmo", 32'(bus_b.err_timeout), 1);
    check("t4_flat", 32'(bus_b.err_flat), 0);
    check("t4_vmax", 32'(bus_b.vmax), 200);
    check("t4_vmin", 32'(bus_b.vmin), 55);
    check("t4_vpp", 32'(bus_b.vpp), 145);
    check("t4_psum", 32'(bus_b.period_sum), 0);
    @(posedge clk);
    #1;
    sel = 1'b0;

    // 5: reset in the middle of COUNT, then a clean measurement
    run(0, 1, 8'd4, -1, 120, cyc, got);
    check("t5_no_done_yet", 32'(got), 0);
    check("t5_busy_before_rst", 32'(bus_a.busy), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(bus_a.busy), 0);
    check("t5_rst_vmax", 32'(bus_a.vmax), 0);
    check("t5_rst_vpp", 32'(bus_a.vpp), 0);
    check("t5_rst_done", 32'(bus_a.done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(0, 1, 8'd4, -1, -1, cyc, got);
    check("t5_done", 32'(got), 1);
    check("t5_cycles", 32'(cyc), 162);
    check("t5_psum", 32'(bus_a.period_sum), 80);
    check("t5_vpp", 32'(bus_a.vpp), 145);

    // 6: N=0 acts as 1; a start while busy and one in the done cycle are ignored
    @(posedge clk);
    #1;
    run(0, 1, 8'd0, 50, -1, cyc, got);
    check("t6_done", 32'(got), 1);
    check("t6_cycles", 32'(cyc), 102);
    check("t6_psum", 32'(bus_a.period_sum), 20);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    check("t6_start_in_done_busy", 32'(bus_a.busy), 0);
    check("t6_start_in_done_psum", 32'(bus_a.period_sum), 20);
    check("t6_done_cleared", 32'(bus_a.done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
